div_unit: RTL and testbench
===========================

# div_unit

Iterative multi-cycle integer divider for the EX stage of the pipelined CPU. It executes the RV32M DIV, DIVU, REM and REMU instructions with a radix-2 restoring algorithm. It is the inverse companion of the single-cycle ALU multiply. It raises `busy_o` so the hazard unit stalls the pipeline, and it returns one 32-bit result with a one-cycle `valid_o` pulse.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width.

Ports:
- `clk_i` input 1: the single clock; all state changes on the rising edge.
- `rst_i` input 1: asynchronous, active-high reset.
- `start_i` input 1: request a division; sampled only in IDLE.
- `flush_i` input 1: abort the operation in flight (branch mispredict or pipeline flush).
- `op_i` input 2: operation select, latched at start.
  - 00: DIV
  - 01: DIVU
  - 10: REM
  - 11: REMU
- `dividend_i` input WIDTH: rs1 value, latched at start.
- `divisor_i` input WIDTH: rs2 value, latched at start.
- `busy_o` output 1: high while an operation is in progress; the hazard unit stalls on it.
- `valid_o` output 1: one-cycle pulse when `data_o` is new.
- `data_o` output WIDTH: quotient or remainder; holds its value until the next `valid_o`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - `start_i` and not `flush_i`: latch `op_i` and the operands.
  - Signed ops (DIV, REM): take the absolute values; record the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign).
  - Divisor == 0: quotient = all ones (0xFFFFFFFF); remainder = dividend unmodified. Go to DONE.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0. Go to DONE.
  - Otherwise: clear the partial remainder, load the 6-bit iteration counter with WIDTH-1, and go to CALC.
- CALC, one restoring step per cycle:
  - Shift {remainder, quotient} left by 1 and shift in the next dividend MSB.
  - Trial-subtract the divisor using WIDTH+1-bit arithmetic.
  - If the difference is non-negative, keep it and set quotient bit 0 to 1; otherwise restore and set it to 0.
  - When the counter reaches 0, go to FIX; otherwise decrement the counter.
- FIX:
  - Apply the two's-complement sign correction to the quotient and/or the remainder (signed ops only).
  - Select the quotient (DIV/DIVU) or the remainder (REM/REMU) into `data_o`.
  - Go to DONE.
- DONE: `valid_o` = 1 for this cycle only; go to IDLE unconditionally. `start_i` is ignored in this cycle.
- `flush_i` in any state: go to IDLE on the next edge. `valid_o` is not asserted and `data_o` is unchanged. `flush_i` has priority over `start_i` in the same cycle.
- `start_i` in CALC or FIX is ignored; operands are not re-latched.

## Timing
- Reset values: state = IDLE, `busy_o` = 0, `valid_o` = 0, `data_o` = 0, all internal registers = 0.
- Reset asserted mid-operation aborts immediately and asynchronously; no `valid_o` follows.
- Normal path, with `start_i` sampled at edge 0:
  - Cycles 1–32: CALC.
  - Cycle 33: FIX.
  - Cycle 34: DONE, `valid_o` = 1.
  - Latency is 34 cycles.
- Special cases (divide by zero, signed overflow): DONE in cycle 1; latency is 1 cycle.
- `busy_o` = 1 in CALC and FIX and 0 in IDLE and DONE. It is a registered output derived from the state.
- `data_o` is registered and updates on the edge that enters DONE.
- The next `start_i` is accepted at the earliest in the cycle after DONE.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - In IDLE, if |dividend| < |divisor| (unsigned compare after the abs step), skip CALC and go to FIX with quotient = 0 and remainder = |dividend|.
  - Latency is 2 cycles.
- `DIV_EARLY_OUT_EN` undefined: these operands take the full 34-cycle path. Results are bit-identical either way.

## Structure
- Package `div_pkg`:
  - `WIDTH` default.
  - The `op_i` encodings (`DIV_OP_DIV`, `DIV_OP_DIVU`, `DIV_OP_REM`, `DIV_OP_REMU`).
  - The state enum (`DIV_IDLE`, `DIV_CALC`, `DIV_FIX`, `DIV_DONE`).
  - The constants `DIV_ZERO_Q` (all ones) and `DIV_MIN_INT` (0x80000000).
- Sub-module `div_step`, purely combinational:
  - Inputs: partial remainder, quotient, and divisor.
  - Outputs: the shifted/subtracted next remainder and the next quotient.
  - Instantiated once and fed back from the CALC registers.

## Test plan
- DIVU 100 / 7 -> `busy_o` high in cycles 1–33; `valid_o` only in cycle 34; `data_o` = 14. REMU 100 / 7 -> 2.
- DIV -7 / 2 -> 0xFFFFFFFD (-3); REM -7 / 2 -> 0xFFFFFFFF (-1); DIV 7 / -2 -> -3; REM 7 / -2 -> 1.
- DIV 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0. All four have `valid_o` in cycle 1.
- DIVU 0xFFFFFFFF / 1 -> 0xFFFFFFFF in 34 cycles. DIVU 3 / 10 -> 0, in 2 cycles with `DIV_EARLY_OUT_EN` and 34 cycles without.
- Edge cases:
  - `flush_i` in cycle 10: IDLE at cycle 11, no `valid_o`, `data_o` keeps its prior value.
  - `start_i` and `flush_i` together in IDLE: no start.
  - `rst_i` pulse mid-CALC: all outputs 0 immediately.
- Back-to-back: a second `start_i` held high through DONE is accepted in the following IDLE cycle. `start_i` toggled during CALC does not change the result.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants, op encodings and state enum for div_unit
package div_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q  = {DIV_WIDTH{1'b1}};
  localparam logic [DIV_WIDTH-1:0] DIV_MIN_INT = {1'b1, {(DIV_WIDTH-1){1'b0}}};

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring division step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The quotient register still holds the unconsumed dividend bits, so its MSB feeds the remainder.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, divisor_i};
    if (!diff[WIDTH]) begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative RV32M DIV/DIVU/REM/REMU unit
// Optional DIV_EARLY_OUT_EN skips CALC when |dividend| < |divisor|.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  div_state_e       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, data_q, data_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic             busy_q, busy_d, valid_q, valid_d;

  logic             signed_op, a_neg, b_neg, div_zero, overflow, early, accept;
  logic [WIDTH-1:0] abs_a, abs_b, step_rem, step_quo, q_fix, r_fix;

  assign accept    = start_i && !flush_i;
  assign signed_op = (op_i == DIV_OP_DIV) || (op_i == DIV_OP_REM);
  assign a_neg     = signed_op && dividend_i[WIDTH-1];
  assign b_neg     = signed_op && divisor_i[WIDTH-1];
  assign abs_a     = a_neg ? -dividend_i : dividend_i;
  assign abs_b     = b_neg ? -divisor_i : divisor_i;
  assign div_zero  = (divisor_i == '0);
  assign overflow  = signed_op && (dividend_i == DIV_MIN_INT) && (divisor_i == DIV_ZERO_Q);
`ifdef DIV_EARLY_OUT_EN
  assign early     = (abs_a < abs_b);
`else
  assign early     = 1'b0;
`endif

  assign q_fix = qneg_q ? -quo_q : quo_q;
  assign r_fix = rneg_q ? -rem_q : rem_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= DIV_IDLE;
      op_q    <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: begin
        if (accept) begin
          if (div_zero || overflow) state_d = DIV_DONE;
          else if (early)           state_d = DIV_FIX;
          else                      state_d = DIV_CALC;
        end
      end
      DIV_CALC: if (cnt_q == '0) state_d = DIV_FIX;
      DIV_FIX:  state_d = DIV_DONE;
      default:  state_d = DIV_IDLE;
    endcase
    if (flush_i) state_d = DIV_IDLE;
  end

  // Datapath and registered outputs; status flags follow the state being entered.
  always_comb begin
    op_d    = op_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    busy_d  = (state_d == DIV_CALC) || (state_d == DIV_FIX);
    valid_d = (state_d == DIV_DONE);
    case (state_q)
      DIV_IDLE: begin
        if (accept) begin
          op_d   = op_i;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          dvs_d  = abs_b;
          if (div_zero) begin
            data_d = op_i[1] ? dividend_i : DIV_ZERO_Q;
          end else if (overflow) begin
            data_d = op_i[1] ? '0 : DIV_MIN_INT;
          end else if (early) begin
            quo_d = '0;
            rem_d = abs_a;
          end else begin
            quo_d = abs_a;
            rem_d = '0;
            cnt_d = 6'(WIDTH - 1);
          end
        end
      end
      DIV_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - 6'd1;
      end
      DIV_FIX: begin
        if (!flush_i) data_d = op_q[1] ? r_fix : q_fix;
      end
      default: ;
    endcase
  end

  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic        busy_o, valid_o;
  logic [31:0] data_o;

  int n_checks = 0;
  int n_errors = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = 34;
`endif

  div_unit #(.WIDTH(32)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .flush_i    (flush_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .data_o     (data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input int lat, input logic [31:0] exp);
    int  cyc;
    int  busy_n;
    bit  seen;
    @(negedge clk_i);
    op_i = op; dividend_i = a; divisor_i = b; start_i = 1'b1;
    cyc = 0; busy_n = 0; seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clk_i);
      cyc++;
      start_i = 1'b0;
      if (valid_o) seen = 1'b1;
      else if (busy_o) busy_n++;
    end
    check({tag, ".lat"}, 32'(cyc), 32'(lat));
    check({tag, ".data"}, data_o, exp);
    check({tag, ".busy_cycles"}, 32'(busy_n), 32'(lat - 1));
    @(negedge clk_i);
    check({tag, ".pulse"}, {31'b0, valid_o}, 32'd0);
  endtask

  initial begin
    int v1, v2, vcount;
    logic [31:0] d1, d2;

    repeat (2) @(negedge clk_i);
    check("reset.busy", {31'b0, busy_o}, 32'd0);
    check("reset.valid", {31'b0, valid_o}, 32'd0);
    check("reset.data", data_o, 32'd0);
    rst_i = 1'b0;

    run("divu_100_7",  2'b01, 32'd100, 32'd7, 34, 32'd14);
    run("remu_100_7",  2'b11, 32'd100, 32'd7, 34, 32'd2);
    run("div_m7_2",    2'b00, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD);
    run("rem_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF);
    run("div_7_m2",    2'b00, 32'd7, 32'hFFFF_FFFE, 34, 32'hFFFF_FFFD);
    run("rem_7_m2",    2'b10, 32'd7, 32'hFFFF_FFFE, 34, 32'd1);
    run("div_m100_m7", 2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 34, 32'd14);
    run("rem_m100_m7", 2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 34, 32'hFFFF_FFFE);
    run("div_5_0",     2'b00, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
    run("remu_5_0",    2'b11, 32'd5, 32'd0, 1, 32'd5);
    run("div_ovf",     2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    run("rem_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);
    run("divu_max_1",  2'b01, 32'hFFFF_FFFF, 32'd1, 34, 32'hFFFF_FFFF);
    run("divu_3_10",   2'b01, 32'd3, 32'd10, EARLY_LAT, 32'd0);
    run("remu_100_7b", 2'b11, 32'd100, 32'd7, 34, 32'd2);

    // Flush in cycle 10 of a long operation.
    @(negedge clk_i);
    op_i = 2'b01; dividend_i = 32'hFFFF_FFFF; divisor_i = 32'd1; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (9) @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check("flush.busy", {31'b0, busy_o}, 32'd0);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (valid_o) vcount++;
    end
    check("flush.no_valid", 32'(vcount), 32'd0);
    check("flush.data_kept", data_o, 32'd2);

    // start and flush together in IDLE.
    op_i = 2'b01; dividend_i = 32'd9; divisor_i = 32'd0; start_i = 1'b1; flush_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; flush_i = 1'b0;
    vcount = 0;
    for (int i = 0; i < 5; i++) begin
      if (valid_o || busy_o) vcount++;
      @(negedge clk_i);
    end
    check("start_flush.no_start", 32'(vcount), 32'd0);
    check("start_flush.data", data_o, 32'd2);

    // start toggled during CALC must not disturb the result.
    op_i = 2'b01; dividend_i = 32'd100; divisor_i = 32'd7; start_i = 1'b1;
    v1 = 0; d1 = '0;
    for (int c = 1; c <= 60 && v1 == 0; c++) begin
      @(negedge clk_i);
      if (c >= 3 && c <= 8) begin
        start_i = c[0]; op_i = 2'b00; dividend_i = 32'd1; divisor_i = 32'd1;
      end else begin
        start_i = 1'b0;
      end
      if (valid_o) begin v1 = c; d1 = data_o; end
    end
    check("toggle.lat", 32'(v1), 32'd34);
    check("toggle.data", d1, 32'd14);

    // Back-to-back with start held through DONE.
    @(negedge clk_i);
    op_i = 2'b01; dividend_i = 32'd100; divisor_i = 32'd7; start_i = 1'b1;
    v1 = 0; v2 = 0; d1 = '0; d2 = '0;
    for (int c = 1; c <= 100 && v2 == 0; c++) begin
      @(negedge clk_i);
      if (c == 1) begin op_i = 2'b11; dividend_i = 32'd50; end
      if (c == 40) start_i = 1'b0;
      if (valid_o && v1 == 0) begin v1 = c; d1 = data_o; end
      else if (valid_o) begin v2 = c; d2 = data_o; end
    end
    start_i = 1'b0;
    check("b2b.first_lat", 32'(v1), 32'd34);
    check("b2b.first_data", d1, 32'd14);
    check("b2b.second_lat", 32'(v2), 32'd69);
    check("b2b.second_data", d2, 32'd1);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk_i);
    op_i = 2'b01; dividend_i = 32'hFFFF_FFFF; divisor_i = 32'd3; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (5) @(negedge clk_i);
    check("rst_mid.pre_busy", {31'b0, busy_o}, 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("rst_mid.busy", {31'b0, busy_o}, 32'd0);
    check("rst_mid.valid", {31'b0, valid_o}, 32'd0);
    check("rst_mid.data", data_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (valid_o) vcount++;
    end
    check("rst_mid.no_valid", 32'(vcount), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
